// File: rtl/fetch_seq.sv
// fetch_seq: three-phase FETCH/DECODE/EXEC sequencer with a 16x8 programmable instruction ROM
module fetch_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              run,
  input  logic [ADDR_W-1:0] PC_addr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              IPC,
  output logic [DATA_W-1:0] IR,
  output logic              IR_valid,
  output logic [1:0]        phase,
  output logic              halted,
  output logic [7:0]        instr_cnt
);
  // Low two bits are the phase code and bit 2 marks HALT, so both outputs come straight off flops.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_HALT   = 3'b111
  } state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_rom [2**ADDR_W];
  logic [DATA_W-1:0] r_rd, r_ir;
  logic [7:0] r_cnt;
  logic w_hlt, w_prog_ok;
  assign w_hlt = r_ir[DATA_W-1 -: 4] == HLT_OP;
  assign w_prog_ok = !CLR && prog_we && (r_state == S_IDLE || r_state == S_HALT);
  assign IR = r_ir;
  assign instr_cnt = r_cnt;
  assign phase = r_state[1:0];
  assign halted = r_state[2];
  // state register
  always_ff @(posedge clk)
    if (CLR) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state: run drop only takes effect at instruction boundaries
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = w_hlt ? S_HALT : (run ? S_FETCH : S_IDLE);
      S_HALT:   w_next = run ? S_HALT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // Moore strobes decoded from registered state and IR only
  always_comb begin
    IPC = r_state == S_EXEC && !w_hlt;
    IR_valid = r_state == S_DECODE;
  end
  // ROM writes only while idle or halted; contents survive CLR
  always_ff @(posedge clk)
    if (w_prog_ok) r_rom[prog_addr] <= prog_data;
  // ROM read at end of FETCH, IR load at end of DECODE, saturating retire count
  always_ff @(posedge clk)
    if (CLR) begin
      r_rd <= '0;
      r_ir <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_FETCH) r_rd <= r_rom[PC_addr];
      if (r_state == S_DECODE) r_ir <= r_rd;
      if (IPC && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
endmodule
